// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: bus widths, FSM states,
// request source tag and the strobe bundle driven onto the SRAM pins.
package mem_arbiter_pkg;

    // Bus-width defaults
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_SRAM_ADDR_W = 18;
    localparam int MAX_WAIT_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } state_e;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic drive;
    } strobe_t;

    localparam strobe_t STRB_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, drive: 1'b0};

    // Strobe pattern that must be on the pins while the FSM sits in a state
    function automatic strobe_t strobes_for(state_e st);
        strobe_t s;
        case (st)
            ST_RD:                   s = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, drive: 1'b0};
            ST_WR_SETUP, ST_WR_HOLD: s = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, drive: 1'b1};
            ST_WR_PULSE:             s = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, drive: 1'b1};
            default:                 s = STRB_IDLE;
        endcase
        return s;
    endfunction

    // The wait counter is two bits wide, so only 0..3 extra cycles fit
    function automatic bit wait_cycles_ok(int w);
        return (w >= 0) && (w <= MAX_WAIT_CYCLES);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU request ports and SRAM pins of the arbiter, named from the
// arbiter's point of view. slave = arbiter, master = CPU/board side.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W
);
    logic                   inst_en_i;
    logic [ADDR_W-1:0]      inst_addr_i;
    logic [DATA_W-1:0]      inst_data_o;
    logic                   inst_valid_o;
    logic                   mem_re_i;
    logic                   mem_we_i;
    logic [ADDR_W-1:0]      mem_addr_i;
    logic [DATA_W-1:0]      mem_wdata_i;
    logic [DATA_W-1:0]      mem_rdata_o;
    logic                   mem_done_o;
    logic                   pause_o;
    logic [SRAM_ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0]      sram_wdata_o;
    logic [DATA_W-1:0]      sram_rdata_i;
    logic                   sram_drive_o;
    logic                   sram_ce_n_o;
    logic                   sram_oe_n_o;
    logic                   sram_we_n_o;

    modport slave (
        input  inst_en_i, inst_addr_i, mem_re_i, mem_we_i, mem_addr_i, mem_wdata_i, sram_rdata_i,
        output inst_data_o, inst_valid_o, mem_rdata_o, mem_done_o, pause_o,
               sram_addr_o, sram_wdata_o, sram_drive_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o
    );

    modport master (
        output inst_en_i, inst_addr_i, mem_re_i, mem_we_i, mem_addr_i, mem_wdata_i, sram_rdata_i,
        input  inst_data_o, inst_valid_o, mem_rdata_o, mem_done_o, pause_o,
               sram_addr_o, sram_wdata_o, sram_drive_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one asynchronous SRAM between instruction fetch and MEM-stage
// data accesses. Data wins over fetch; every SRAM pin is a flop so the
// request inputs never reach the pins combinationally, and the async
// reset pulls all strobes inactive without a we_n glitch.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    if (!wait_cycles_ok(WAIT_CYCLES)) begin : g_bad_wait
        $error("mem_arbiter: WAIT_CYCLES must be in 0..3");
    end
    if (SRAM_ADDR_W < ADDR_W) begin : g_bad_addr
        $error("mem_arbiter: SRAM_ADDR_W must be >= ADDR_W");
    end

    localparam logic [1:0] W_INIT = 2'(WAIT_CYCLES);

    state_e                 state_q;
    logic [1:0]             cnt_q;
    src_e                   src_q;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      inst_data_q;
    logic [DATA_W-1:0]      mem_rdata_q;
    logic                   inst_valid_q;
    logic                   mem_done_q;
    strobe_t                strb_q;

    // Access sequencer: strobes are loaded with the pattern of the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            src_q        <= SRC_INST;
            addr_q       <= '0;
            wdata_q      <= '0;
            inst_data_q  <= '0;
            mem_rdata_q  <= '0;
            inst_valid_q <= 1'b0;
            mem_done_q   <= 1'b0;
            strb_q       <= STRB_IDLE;
        end else begin
            inst_valid_q <= 1'b0;
            mem_done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // re+we together is a write
                    if (bus.mem_we_i) begin
                        src_q   <= SRC_DATA;
                        addr_q  <= SRAM_ADDR_W'(bus.mem_addr_i);
                        wdata_q <= bus.mem_wdata_i;
                        state_q <= ST_WR_SETUP;
                        strb_q  <= strobes_for(ST_WR_SETUP);
                    end else if (bus.mem_re_i) begin
                        src_q   <= SRC_DATA;
                        addr_q  <= SRAM_ADDR_W'(bus.mem_addr_i);
                        cnt_q   <= W_INIT;
                        state_q <= ST_RD;
                        strb_q  <= strobes_for(ST_RD);
                    end else if (bus.inst_en_i) begin
                        src_q   <= SRC_INST;
                        addr_q  <= SRAM_ADDR_W'(bus.inst_addr_i);
                        cnt_q   <= W_INIT;
                        state_q <= ST_RD;
                        strb_q  <= strobes_for(ST_RD);
                    end
                end
                ST_RD: begin
                    if (cnt_q == 2'd0) begin
                        if (src_q == SRC_INST) begin
                            inst_data_q  <= bus.sram_rdata_i;
                            inst_valid_q <= 1'b1;
                        end else begin
                            mem_rdata_q <= bus.sram_rdata_i;
                            mem_done_q  <= 1'b1;
                        end
                        state_q <= ST_DONE;
                        strb_q  <= STRB_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_WR_SETUP: begin
                    cnt_q   <= W_INIT;
                    state_q <= ST_WR_PULSE;
                    strb_q  <= strobes_for(ST_WR_PULSE);
                end
                ST_WR_PULSE: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= ST_WR_HOLD;
                        strb_q  <= strobes_for(ST_WR_HOLD);
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ST_WR_HOLD: begin
                    mem_done_q <= 1'b1;
                    state_q    <= ST_DONE;
                    strb_q     <= STRB_IDLE;
                end
                // Requester still holds its request here; ignore it
                ST_DONE: state_q <= ST_IDLE;
                default: begin
                    state_q <= ST_IDLE;
                    strb_q  <= STRB_IDLE;
                end
            endcase
        end
    end

    assign bus.inst_data_o  = inst_data_q;
    assign bus.inst_valid_o = inst_valid_q;
    assign bus.mem_rdata_o  = mem_rdata_q;
    assign bus.mem_done_o   = mem_done_q;
    assign bus.sram_addr_o  = addr_q;
    assign bus.sram_wdata_o = wdata_q;
    assign bus.sram_ce_n_o  = strb_q.ce_n;
    assign bus.sram_oe_n_o  = strb_q.oe_n;
    assign bus.sram_we_n_o  = strb_q.we_n;
    assign bus.sram_drive_o = strb_q.drive;

    // Stall while any request is outstanding; released in its completion cycle
    assign bus.pause_o = rst & (((bus.mem_re_i | bus.mem_we_i) & ~mem_done_q) |
                                (bus.inst_en_i & ~inst_valid_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: W=1 instance with an SRAM model and a
// completion scoreboard, plus W=0 / W=3 instances for latency sweeps.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int SAW = 18;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SRAM_ADDR_W(SAW)) b1 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SRAM_ADDR_W(SAW)) b0 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SRAM_ADDR_W(SAW)) b3 ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SRAM_ADDR_W(SAW), .WAIT_CYCLES(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SRAM_ADDR_W(SAW), .WAIT_CYCLES(0))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SRAM_ADDR_W(SAW), .WAIT_CYCLES(3))
        dut3 (.clk(clk), .rst(rst), .bus(b3));

    // SRAM model for the W=1 instance (low address byte selects the word)
    logic [15:0] mem [0:255];
    assign b1.sram_rdata_i = (!b1.sram_ce_n_o && !b1.sram_oe_n_o) ? mem[b1.sram_addr_o[7:0]] : 16'hDEAD;
    always @(posedge b1.sram_we_n_o)
        if (rst && !b1.sram_ce_n_o) mem[b1.sram_addr_o[7:0]] = b1.sram_wdata_o;

    assign b0.sram_rdata_i = 16'h1234;
    assign b3.sram_rdata_i = 16'h4321;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Scoreboard: expected completions with the cycle they must appear in
    typedef struct {
        bit          rd;
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t inst_q[$];
    exp_t data_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (rst && b1.inst_valid_o) begin
            if (inst_q.size() == 0) chk("inst_unexpected_pulse", 1, 0);
            else begin
                e = inst_q.pop_front();
                chk("inst_data", b1.inst_data_o, e.data);
                chk("inst_cycle", cyc, e.cyc);
            end
        end
        if (rst && b1.mem_done_o) begin
            if (data_q.size() == 0) chk("data_unexpected_pulse", 1, 0);
            else begin
                e = data_q.pop_front();
                if (e.rd) chk("mem_rdata", b1.mem_rdata_o, e.data);
                chk("data_cycle", cyc, e.cyc);
            end
        end
    end

    // Wait for a W=1 completion pulse, bounded
    task automatic wait_b1(input bit inst, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(inst ? b1.inst_valid_o : b1.mem_done_o) && n < 30);
        if (!(inst ? b1.inst_valid_o : b1.mem_done_o)) chk({nm, "_timeout"}, 1, 0);
    endtask

    function automatic logic done_of(input int w);
        return (w == 0) ? b0.mem_done_o : b3.mem_done_o;
    endfunction

    task automatic set_req(input int w, input logic re, input logic we);
        if (w == 0) begin b0.mem_re_i = re; b0.mem_we_i = we; end
        else        begin b3.mem_re_i = re; b3.mem_we_i = we; end
    endtask

    // Read latency and we_n-low width for the W=0 / W=3 instances
    task automatic sweep(input int w);
        int n;
        int wid;
        logic [15:0] rd;
        set_req(w, 1'b1, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!done_of(w) && n < 20);
        rd = (w == 0) ? b0.mem_rdata_o : b3.mem_rdata_o;
        chk((w == 0) ? "w0_rd_latency" : "w3_rd_latency", n, (w == 0) ? 2 : 5);
        chk((w == 0) ? "w0_rdata" : "w3_rdata", rd, (w == 0) ? 16'h1234 : 16'h4321);
        set_req(w, 1'b0, 1'b0);
        @(negedge clk);
        set_req(w, 1'b0, 1'b1);
        n = 0;
        wid = 0;
        do begin
            @(negedge clk);
            n++;
            if (((w == 0) ? b0.sram_we_n_o : b3.sram_we_n_o) == 1'b0) wid++;
        end while (!done_of(w) && n < 20);
        chk((w == 0) ? "w0_we_low_width" : "w3_we_low_width", wid, (w == 0) ? 1 : 4);
        chk((w == 0) ? "w0_wr_latency" : "w3_wr_latency", n, (w == 0) ? 4 : 7);
        set_req(w, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    logic [3:0] wr_strb [5];
    logic       wr_pause [5];

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h40] = 16'h6C10;
        mem[8'h12] = 16'hBEEF;
        // {ce_n, oe_n, we_n, drive} for SETUP, PULSE, PULSE, HOLD, DONE
        wr_strb  = '{4'b0111, 4'b0101, 4'b0101, 4'b0111, 4'b1110};
        wr_pause = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        b1.inst_en_i = 1'b0; b1.inst_addr_i = '0; b1.mem_re_i = 1'b0; b1.mem_we_i = 1'b0;
        b1.mem_addr_i = '0;  b1.mem_wdata_i = '0;
        b0.inst_en_i = 1'b0; b0.inst_addr_i = '0; b0.mem_re_i = 1'b0; b0.mem_we_i = 1'b0;
        b0.mem_addr_i = '0;  b0.mem_wdata_i = '0;
        b3.inst_en_i = 1'b0; b3.inst_addr_i = '0; b3.mem_re_i = 1'b0; b3.mem_we_i = 1'b0;
        b3.mem_addr_i = '0;  b3.mem_wdata_i = '0;

        // ---- reset values ----
        rst = 1'b1;
        #1 rst = 1'b0;
        b1.inst_en_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ce_n", b1.sram_ce_n_o, 1);
        chk("rst_oe_n", b1.sram_oe_n_o, 1);
        chk("rst_we_n", b1.sram_we_n_o, 1);
        chk("rst_drive", b1.sram_drive_o, 0);
        chk("rst_addr", b1.sram_addr_o, 0);
        chk("rst_wdata", b1.sram_wdata_o, 0);
        chk("rst_inst_data", b1.inst_data_o, 0);
        chk("rst_mem_rdata", b1.mem_rdata_o, 0);
        chk("rst_pulses", {b1.inst_valid_o, b1.mem_done_o}, 0);
        chk("rst_pause_forced_low", b1.pause_o, 0);
        chk("rst_state", dut1.state_q, ST_IDLE);
        b1.inst_en_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // ---- fetch, W=1 ----
        k = cyc;
        b1.inst_en_i = 1'b1; b1.inst_addr_i = 16'h0040;
        inst_q.push_back('{rd: 1'b1, data: 16'h6C10, cyc: k + 3});
        @(negedge clk);
        chk("fetch_sram_addr", b1.sram_addr_o, 18'h00040);
        chk("fetch_rd_strobes", {b1.sram_ce_n_o, b1.sram_oe_n_o, b1.sram_we_n_o, b1.sram_drive_o}, 4'b0010);
        wait_b1(1'b1, "fetch");
        b1.inst_en_i = 1'b0; b1.inst_addr_i = 16'h0000;
        repeat (2) @(negedge clk);
        chk("inst_data_held", b1.inst_data_o, 16'h6C10);

        // ---- data write, W=1, with inputs changed mid-pulse ----
        k = cyc;
        b1.mem_we_i = 1'b1; b1.mem_addr_i = 16'hBF00; b1.mem_wdata_i = 16'h00AA;
        data_q.push_back('{rd: 1'b0, data: 16'h0000, cyc: k + 5});
        #1 chk("wr_pause_at_request", b1.pause_o, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wr_strobes", {b1.sram_ce_n_o, b1.sram_oe_n_o, b1.sram_we_n_o, b1.sram_drive_o}, wr_strb[i]);
            chk("wr_pause", b1.pause_o, wr_pause[i]);
            if (i == 1) begin
                b1.mem_addr_i = 16'h1234; b1.mem_wdata_i = 16'hFFFF;
            end
            if (i == 2 || i == 3) begin
                chk("wr_latched_addr", b1.sram_addr_o, 18'h0BF00);
                chk("wr_latched_data", b1.sram_wdata_o, 16'h00AA);
            end
        end
        b1.mem_we_i = 1'b0;
        @(negedge clk);

        // ---- read back the written word ----
        k = cyc;
        b1.mem_re_i = 1'b1; b1.mem_addr_i = 16'hBF00;
        data_q.push_back('{rd: 1'b1, data: 16'h00AA, cyc: k + 3});
        wait_b1(1'b0, "readback");
        b1.mem_re_i = 1'b0;
        @(negedge clk);

        // ---- contention: data read first, fetch the cycle after DONE ----
        k = cyc;
        b1.inst_en_i = 1'b1; b1.inst_addr_i = 16'h0012;
        b1.mem_re_i  = 1'b1; b1.mem_addr_i  = 16'h0040;
        data_q.push_back('{rd: 1'b1, data: 16'h6C10, cyc: k + 3});
        inst_q.push_back('{rd: 1'b1, data: 16'hBEEF, cyc: k + 7});
        wait_b1(1'b0, "contention_read");
        b1.mem_re_i = 1'b0;
        #1 chk("cont_pause_after_read", b1.pause_o, 1);
        for (int i = 0; i < 10 && !b1.inst_valid_o; i++) begin
            @(negedge clk);
            if (!b1.inst_valid_o) chk("cont_pause_waiting", b1.pause_o, 1);
        end
        chk("cont_fetch_done", b1.inst_valid_o, 1);
        chk("cont_pause_in_done", b1.pause_o, 0);
        b1.inst_en_i = 1'b0;
        @(negedge clk);

        // ---- reset in the middle of WR_PULSE ----
        b1.mem_we_i = 1'b1; b1.mem_addr_i = 16'h0077; b1.mem_wdata_i = 16'h5555;
        repeat (2) @(negedge clk);
        chk("midrst_in_pulse", b1.sram_we_n_o, 0);
        rst = 1'b0;
        #1;
        chk("midrst_we_n_immediate", b1.sram_we_n_o, 1);
        chk("midrst_ce_n_immediate", b1.sram_ce_n_o, 1);
        chk("midrst_drive_immediate", b1.sram_drive_o, 0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_done", b1.mem_done_o, 0);
        end
        b1.mem_we_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_state_idle", dut1.state_q, ST_IDLE);
        chk("midrst_no_write", mem[8'h77], 16'h0000);
        @(negedge clk);

        // ---- W sweep ----
        sweep(0);
        sweep(3);

        repeat (3) @(negedge clk);
        chk("inst_queue_drained", inst_q.size(), 0);
        chk("data_queue_drained", data_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences a single asynchronous SRAM shared between the CPU's instruction-fetch port and its MEM-stage data port. Each request is latched, the SRAM control strobes are driven through a multi-cycle read or write sequence, and a one-cycle completion pulse is returned. The CPU's pipeline pause is asserted while a request is pending. The block sits between `cpu` and the board-level SRAM pins; the top level owns the tristate data bus.

## Interface
Parameters:
- ADDR_W, 16, CPU address width (instruction and data).
- DATA_W, 16, word width.
- SRAM_ADDR_W, 18, SRAM address pins; CPU address is zero-extended.
- WAIT_CYCLES, 1, extra SRAM access cycles W. Legal range 0..3.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- inst_en_i  in  1  fetch request; held until inst_valid_o.
- inst_addr_i  in  ADDR_W  fetch address.
- inst_data_o  out  DATA_W  fetched word; valid while inst_valid_o=1, held afterwards.
- inst_valid_o  out  1  one-cycle fetch-complete pulse.
- mem_re_i  in  1  data read request; held until mem_done_o.
- mem_we_i  in  1  data write request; held until mem_done_o.
- mem_addr_i  in  ADDR_W  data address.
- mem_wdata_i  in  DATA_W  write data.
- mem_rdata_o  out  DATA_W  read data; valid while mem_done_o=1, held afterwards.
- mem_done_o  out  1  one-cycle data-complete pulse.
- pause_o  out  1  pipeline stall request to the CPU.
- sram_addr_o  out  SRAM_ADDR_W  SRAM address.
- sram_wdata_o  out  DATA_W  data to drive onto the SRAM bus.
- sram_rdata_i  in  DATA_W  data sampled from the SRAM bus.
- sram_drive_o  out  1  tristate enable for sram_wdata_o.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low SRAM strobes.

## Operation
FSM states and transitions:
- IDLE. If a data request is present, the data request wins over a fetch. Otherwise a fetch is accepted if present.
  - Data read goes to RD.
  - Data write goes to WR_SETUP.
  - Fetch goes to RD with the fetch source tag.
- On acceptance, the address, write data and source tag are latched. Later input changes are ignored until completion.
- RD lasts W+1 cycles.
  - ce_n=0, oe_n=0, drive=0.
  - At the edge ending the last RD cycle, sram_rdata_i is registered into inst_data_o or mem_rdata_o according to the source tag. The FSM then goes to DONE.
- WR_SETUP lasts 1 cycle: ce_n=0, oe_n=1, we_n=1, drive=1.
- WR_PULSE lasts W+1 cycles: we_n=0, drive=1.
- WR_HOLD lasts 1 cycle: we_n=1, drive=1, address and data unchanged. The FSM then goes to DONE.
- DONE lasts 1 cycle.
  - inst_valid_o or mem_done_o is 1.
  - All strobes are inactive.
  - Requests are ignored, because the requester still holds its request in this cycle.
  - The FSM then goes to IDLE.
- mem_re_i and mem_we_i both high is treated as a write.
- Address mapping: sram_addr_o = {zeros, latched addr}.
- pause_o is combinational: ((mem_re_i|mem_we_i) & ~mem_done_o) | (inst_en_i & ~inst_valid_o). It is forced to 0 while rst=0.

## Timing
- Read latency: request present in IDLE cycle k, so completion pulse in cycle k+W+2. Back-to-back throughput is W+3 cycles.
- Write latency: request in cycle k, so mem_done_o in cycle k+W+4.
- Fetch starvation is bounded. DONE always returns to IDLE, and after a data completion the CPU advances, so the next data request cannot appear in the cycle directly after DONE.
- Reset values:
  - ce_n, oe_n and we_n are 1; drive is 0.
  - sram_addr_o, sram_wdata_o, inst_data_o and mem_rdata_o are 0.
  - inst_valid_o and mem_done_o are 0.
  - The FSM is in IDLE.
- Reset mid-access: strobes deassert immediately, which is asynchronous. The access is aborted with no completion pulse. we_n must never glitch low on reset.
- Strobes and sram_addr_o/sram_wdata_o are registered outputs: no combinational path from request inputs to SRAM pins.

## Structure
- State encoding, the source tag (SRC_INST / SRC_DATA) and the WAIT_CYCLES range check are added to the shared defines, alongside the existing bus-width macros.
- No sub-module. The wait counter is a 2-bit down-counter inside the FSM.

## Test plan
- Reset: drive rst=0 mid-WR_PULSE → we_n_o=1 in the same cycle, no mem_done_o; after release the FSM is in IDLE.
- Fetch, W=1: inst_en_i=1, addr 0x0040, SRAM returns 0x6C10 → inst_valid_o high exactly 3 cycles after request; inst_data_o=0x6C10; sram_addr_o=0x00040.
- Data write, W=1: mem_we_i, addr 0xBF00, data 0x00AA → sequence setup 1, we_n low 2, hold 1; mem_done_o in cycle k+5; drive=1 throughout; pause_o high until the done cycle.
- Contention: inst_en_i and mem_re_i asserted in the same cycle → data read serviced first. Fetch starts the cycle after DONE; pause_o stays high until inst_valid_o.
- Input change mid-access: change mem_addr_i and mem_wdata_i during WR_PULSE → SRAM still sees the latched values.
- W=0 and W=3 sweep: read latency is 2 and 5 cycles; write we_n-low width is 1 and 4 cycles.
